id_stage_mseq: RTL and testbench
================================

Name: id_stage_mseq

Overview:
- Parametrised instruction-decode stage for the 6-stage RISC pipeline. Sits between fetch and register-read (RR).
- Decodes every opcode group into register-read fields, resolves the JAL target, and expands LM/SM into one micro-op per set mask bit.
- Uses a valid/ready handshake on both sides instead of freeze counters. Synchronous flush input.

Parameters:
- PC_W, 16, width of the PC and of jloc.
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4].
- RA_W, 3, register address width.
- MASK_W, 8, LM/SM register mask width, taken from instr[MASK_W-1:0]. Must satisfy MASK_W <= 2**RA_W.
- OFF_STEP, 1, address increment between consecutive LM/SM micro-ops.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr  in  INSTR_W  instruction from fetch
- PC_in  in  PC_W  PC of instr
- valid_f  in  1  fetch presents a valid instruction
- in_ready  out  1  stage accepts instr this cycle
- flush  in  1  discard the held and in-progress instruction
- out_ready  in  1  RR accepts the current output
- valid_out  out  1  output fields valid
- opcode  out  4  decoded opcode
- ra, rb, rc  out  RA_W each  source A, source B, writeback register
- imm6  out  6  6-bit immediate
- imm9  out  9  9-bit immediate
- ccz  out  3  condition/complement field
- PC_out  out  PC_W  PC of the instruction
- regsel  out  1  register file read required
- jloc  out  PC_W  JAL target
- jvalid  out  1  jloc valid
- uop  out  1  output is an LM/SM micro-op
- uop_last  out  1  final micro-op of an LM/SM
- mem_off  out  PC_W  micro-op address offset from ra
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Interface fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset: all outputs 0, state IDLE. in_ready becomes 1 on the first cycle after reset deasserts.
- adv = !valid_out || out_ready. in_ready = adv && state==IDLE && !flush (combinational).
- Accept = valid_f && in_ready. Outputs are registered with 1-cycle latency. When !adv, all outputs hold.
- Field map, using the existing decode table:
  - op 0/2: ra/rb/rc/ccz from [11:9]/[8:6]/[5:3]/[2:0].
  - op 1: ra=[11:9], rc=[8:6], imm6.
  - op 4/12: rc=[11:9], rb=[8:6], imm6.
  - op 5/8/9/10: ra=[11:9], rb=[8:6], imm6.
  - op 3: rc=[11:9], imm9, regsel=0.
  - op 13: ra=[11:9], imm9.
  - op 11: rc=[11:9], jloc = PC_in + sign-extended imm9 (truncated to PC_W), jvalid=1.
  - Unused fields are 0. regsel=1 for every op except 3.
- jvalid is asserted only on the JAL output beat and is cleared on the next advance.
- Illegal opcode (14, 15): the instruction is consumed, valid_out=0, illegal=1 for one cycle.
- LM (6) / SM (7) expansion:
  - On accept, latch mask=instr[MASK_W-1:0], ra, PC. mask==0: consume, emit nothing, stay in IDLE.
  - Otherwise go to EXPAND. Each adv cycle emits one micro-op for the lowest set bit i:
    - LM: rc=i. SM: rb=i.
    - ra = base register, opcode = 6/7, uop=1, mem_off = k*OFF_STEP for the k-th micro-op (k from 0), PC_out = the LM/SM PC.
    - The emitted bit is cleared.
  - uop_last=1 when the emitted bit was the last set bit; the stage returns to IDLE when that beat advances.
  - in_ready=0 throughout EXPAND.
- flush (priority below rst): in the next cycle valid_out/jvalid/uop/uop_last/illegal = 0, state IDLE, mask cleared. An instruction presented in the flush cycle is not accepted.
- rst mid-expansion: same as reset. No partial micro-op survives.
- mem_off width is PC_W; k*OFF_STEP wraps modulo 2**PC_W.

Test Plan:
- ADD r1,r2,r3 (instr 0x0298) with valid_f=1, out_ready=1 -> the next cycle valid_out=1, opcode=0, ra=1, rb=2, rc=3, ccz=0, regsel=1.
- JAL r5 at PC_in=0x0020, imm9=0x1F0 (-16) -> jloc=0x0010, jvalid=1, rc=5 for one beat; 0 afterwards.
- LM r2 mask=0b1001_0010 -> 3 beats: rc=1/4/7, mem_off=0/1/2, uop_last only on the 3rd beat; in_ready=0 for those 3 cycles.
- SM with mask=0x00 -> no valid_out, in_ready=1 the next cycle. Opcode 14 -> illegal pulse, valid_out=0.
- out_ready=0 for 4 cycles during LM expansion -> outputs held constant, no micro-op skipped or duplicated.
- flush asserted on the 2nd LM micro-op -> the next cycle valid_out=0, state IDLE; the following ADD decodes normally.

Source files
------------

// File: rtl/id_stage_mseq.sv
// rtl/id_stage_mseq.sv - instruction decode stage with LM/SM micro-op expansion
//
// Decodes one instruction per accepted handshake into register-read fields,
// resolves the JAL target and expands LM/SM into one micro-op per set mask bit.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr, PC_in          instruction and its PC from fetch
//   valid_f / in_ready    fetch-side handshake
//   flush                 discard held output and any in-progress expansion
//   out_ready / valid_out RR-side handshake
//   opcode, ra, rb, rc, imm6, imm9, ccz, PC_out, regsel   decoded fields
//   jloc, jvalid          JAL target and its qualifier
//   uop, uop_last, mem_off  LM/SM micro-op qualifiers and address offset
//   illegal               one-cycle pulse on an undefined opcode
module id_stage_mseq #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 16,
  parameter int RA_W     = 3,
  parameter int MASK_W   = 8,
  parameter int OFF_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    PC_in,
  input  logic               valid_f,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               valid_out,
  output logic [3:0]         opcode,
  output logic [RA_W-1:0]    ra,
  output logic [RA_W-1:0]    rb,
  output logic [RA_W-1:0]    rc,
  output logic [5:0]         imm6,
  output logic [8:0]         imm9,
  output logic [2:0]         ccz,
  output logic [PC_W-1:0]    PC_out,
  output logic               regsel,
  output logic [PC_W-1:0]    jloc,
  output logic               jvalid,
  output logic               uop,
  output logic               uop_last,
  output logic [PC_W-1:0]    mem_off,
  output logic               illegal
);

  typedef enum logic {IDLE, EXPAND} state_t;

  typedef struct packed {
    logic            valid;
    logic [3:0]      opcode;
    logic [RA_W-1:0] ra;
    logic [RA_W-1:0] rb;
    logic [RA_W-1:0] rc;
    logic [5:0]      imm6;
    logic [8:0]      imm9;
    logic [2:0]      ccz;
    logic [PC_W-1:0] pc;
    logic            regsel;
    logic [PC_W-1:0] jloc;
    logic            jvalid;
    logic            uop;
    logic            uop_last;
    logic [PC_W-1:0] mem_off;
    logic            illegal;
  } out_t;

  state_t            state, state_nx;
  out_t              out_q, out_d;
  logic [MASK_W-1:0] mask_q, mask_d, mask_rest;
  logic [RA_W-1:0]   base_q, base_d, low_idx;
  logic              is_sm_q, is_sm_d;
  logic [PC_W-1:0]   pc_q, pc_d, off_q, off_d;
  logic              adv, accept, last;
  logic [3:0]        op;

  assign op       = instr[INSTR_W-1 -: 4];
  assign adv      = !out_q.valid || out_ready;
  assign in_ready = adv && (state == IDLE) && !flush;
  assign accept   = valid_f && in_ready;

  // Lowest set mask bit is the next micro-op; mask & (mask-1) clears exactly that bit.
  always_comb begin
    low_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = RA_W'(i);
    end
  end
  assign mask_rest = mask_q & (mask_q - MASK_W'(1));
  assign last      = (mask_rest == '0);

  // State register together with the output/datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out_q   <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      is_sm_q <= 1'b0;
      pc_q    <= '0;
      off_q   <= '0;
    end else begin
      state   <= state_nx;
      out_q   <= out_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      is_sm_q <= is_sm_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
    end
  end

  // Next-state logic. The last micro-op returns to IDLE as it is emitted, so a
  // new instruction can be accepted while that beat is being consumed.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept && (op == 4'd6 || op == 4'd7) && instr[MASK_W-1:0] != '0)
                state_nx = EXPAND;
        EXPAND: if (adv && last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    base_d  = base_q;
    is_sm_d = is_sm_q;
    pc_d    = pc_q;
    off_d   = off_q;
    if (flush) begin
      out_d  = '0;
      mask_d = '0;
    end else if (adv) begin
      out_d = '0;
      if (state == EXPAND) begin
        out_d.valid    = 1'b1;
        out_d.opcode   = is_sm_q ? 4'd7 : 4'd6;
        out_d.ra       = base_q;
        if (is_sm_q) out_d.rb = low_idx;
        else         out_d.rc = low_idx;
        out_d.regsel   = 1'b1;
        out_d.pc       = pc_q;
        out_d.uop      = 1'b1;
        out_d.uop_last = last;
        out_d.mem_off  = off_q;
        mask_d         = mask_rest;
        off_d          = off_q + PC_W'(OFF_STEP);
      end else if (accept) begin
        out_d.valid  = 1'b1;
        out_d.opcode = op;
        out_d.pc     = PC_in;
        out_d.regsel = 1'b1;
        case (op)
          4'd0, 4'd2: begin
            out_d.ra  = RA_W'(instr[11:9]);
            out_d.rb  = RA_W'(instr[8:6]);
            out_d.rc  = RA_W'(instr[5:3]);
            out_d.ccz = instr[2:0];
          end
          4'd1: begin
            out_d.ra   = RA_W'(instr[11:9]);
            out_d.rc   = RA_W'(instr[8:6]);
            out_d.imm6 = instr[5:0];
          end
          4'd4, 4'd12: begin
            out_d.rc   = RA_W'(instr[11:9]);
            out_d.rb   = RA_W'(instr[8:6]);
            out_d.imm6 = instr[5:0];
          end
          4'd5, 4'd8, 4'd9, 4'd10: begin
            out_d.ra   = RA_W'(instr[11:9]);
            out_d.rb   = RA_W'(instr[8:6]);
            out_d.imm6 = instr[5:0];
          end
          4'd3: begin
            out_d.rc     = RA_W'(instr[11:9]);
            out_d.imm9   = instr[8:0];
            out_d.regsel = 1'b0;
          end
          4'd13: begin
            out_d.ra   = RA_W'(instr[11:9]);
            out_d.imm9 = instr[8:0];
          end
          4'd11: begin
            out_d.rc     = RA_W'(instr[11:9]);
            out_d.jloc   = PC_in + PC_W'({{PC_W{instr[8]}}, instr[8:0]});
            out_d.jvalid = 1'b1;
          end
          4'd6, 4'd7: begin
            // LM/SM: latch the expansion context; nothing is emitted this beat.
            out_d   = '0;
            mask_d  = instr[MASK_W-1:0];
            base_d  = RA_W'(instr[11:9]);
            is_sm_d = (op == 4'd7);
            pc_d    = PC_in;
            off_d   = '0;
          end
          default: begin
            out_d         = '0;
            out_d.illegal = 1'b1;
          end
        endcase
      end
    end
  end

  assign valid_out = out_q.valid;
  assign opcode    = out_q.opcode;
  assign ra        = out_q.ra;
  assign rb        = out_q.rb;
  assign rc        = out_q.rc;
  assign imm6      = out_q.imm6;
  assign imm9      = out_q.imm9;
  assign ccz       = out_q.ccz;
  assign PC_out    = out_q.pc;
  assign regsel    = out_q.regsel;
  assign jloc      = out_q.jloc;
  assign jvalid    = out_q.jvalid;
  assign uop       = out_q.uop;
  assign uop_last  = out_q.uop_last;
  assign mem_off   = out_q.mem_off;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_stage_mseq.sv
// tb/tb_id_stage_mseq.sv - scoreboard bench for id_stage_mseq
module tb_id_stage_mseq;

  logic        clk = 1'b0;
  logic        rst, valid_f, flush, out_ready;
  logic [15:0] instr, PC_in;
  logic        in_ready, valid_out, regsel, jvalid, uop, uop_last, illegal;
  logic [3:0]  opcode;
  logic [2:0]  ra, rb, rc, ccz;
  logic [5:0]  imm6;
  logic [8:0]  imm9;
  logic [15:0] PC_out, jloc, mem_off;

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rc;
    logic [5:0]  imm6;
    logic [8:0]  imm9;
    logic [2:0]  ccz;
    logic [15:0] pc;
    logic        regsel;
    logic [15:0] jloc;
    logic        jvalid;
    logic        uop;
    logic        uop_last;
    logic [15:0] mem_off;
    logic        illegal;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  id_stage_mseq dut (
    .clk(clk), .rst(rst), .instr(instr), .PC_in(PC_in), .valid_f(valid_f),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .valid_out(valid_out), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
    .imm6(imm6), .imm9(imm9), .ccz(ccz), .PC_out(PC_out), .regsel(regsel),
    .jloc(jloc), .jvalid(jvalid), .uop(uop), .uop_last(uop_last),
    .mem_off(mem_off), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic rec_t act();
    rec_t r;
    r = {valid_out, opcode, ra, rb, rc, imm6, imm9, ccz, PC_out, regsel,
         jloc, jvalid, uop, uop_last, mem_off, illegal};
    return r;
  endfunction

  function automatic rec_t mk(input logic [3:0] op, input logic [2:0] a, b, c,
                              input logic [5:0] i6, input logic [8:0] i9,
                              input logic [2:0] cz, input logic [15:0] pc,
                              input logic rs);
    rec_t r = '0;
    r.valid = 1'b1; r.opcode = op; r.ra = a; r.rb = b; r.rc = c;
    r.imm6 = i6; r.imm9 = i9; r.ccz = cz; r.pc = pc; r.regsel = rs;
    return r;
  endfunction

  function automatic rec_t mku(input logic [3:0] op, input logic [2:0] a, b, c,
                               input logic [15:0] pc, input logic [15:0] off,
                               input logic lst);
    rec_t r = mk(op, a, b, c, 6'd0, 9'd0, 3'd0, pc, 1'b1);
    r.uop = 1'b1; r.uop_last = lst; r.mem_off = off;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops and compares every consumed beat and every illegal pulse,
  // and verifies outputs stay frozen while RR stalls.
  rec_t cur, held;
  logic hold_chk = 1'b0;
  logic flush_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_chk   = 1'b0;
      flush_prev = 1'b0;
    end else begin
      cur = act();
      if (hold_chk && !flush_prev) check("hold_during_stall", 128'(cur), 128'(held));
      hold_chk   = valid_out && !out_ready;
      held       = cur;
      flush_prev = flush;
      if ((valid_out && out_ready) || illegal) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          check("beat", 128'(cur), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] pc);
    int   n = 0;
    logic acc;
    instr = i; PC_in = pc; valid_f = 1'b1;
    do begin
      #1; acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    valid_f = 1'b0;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_out && n < 50) begin step(); n++; end
    check("wait_valid", 128'(valid_out), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    rec_t r;
    rst = 1'b1; valid_f = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; PC_in = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_outputs", 128'(act()), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back decode of every field-map group.
    exp_q.push_back(mk(4'd0, 3'd1, 3'd2, 3'd3, 6'd0, 9'd0, 3'd0, 16'h0100, 1'b1));
    issue(16'h0298, 16'h0100);
    exp_q.push_back(mk(4'd1, 3'd4, 3'd0, 3'd5, 6'h2A, 9'd0, 3'd0, 16'h0102, 1'b1));
    issue({4'd1, 3'd4, 3'd5, 6'h2A}, 16'h0102);
    exp_q.push_back(mk(4'd4, 3'd0, 3'd7, 3'd6, 6'h15, 9'd0, 3'd0, 16'h0104, 1'b1));
    issue({4'd4, 3'd6, 3'd7, 6'h15}, 16'h0104);
    exp_q.push_back(mk(4'd3, 3'd0, 3'd0, 3'd2, 6'd0, 9'h1A5, 3'd0, 16'h0106, 1'b0));
    issue({4'd3, 3'd2, 9'h1A5}, 16'h0106);
    exp_q.push_back(mk(4'd13, 3'd3, 3'd0, 3'd0, 6'd0, 9'h0FF, 3'd0, 16'h0108, 1'b1));
    issue({4'd13, 3'd3, 9'h0FF}, 16'h0108);
    exp_q.push_back(mk(4'd9, 3'd1, 3'd2, 3'd0, 6'h3F, 9'd0, 3'd0, 16'h010A, 1'b1));
    issue({4'd9, 3'd1, 3'd2, 6'h3F}, 16'h010A);
    exp_q.push_back(mk(4'd2, 3'd7, 3'd6, 3'd5, 6'd0, 9'd0, 3'd3, 16'h010C, 1'b1));
    issue({4'd2, 3'd7, 3'd6, 3'd5, 3'd3}, 16'h010C);

    // JAL r5, -16 at 0x0020 -> 0x0010; the following beat carries jvalid=0.
    r = mk(4'd11, 3'd0, 3'd0, 3'd5, 6'd0, 9'd0, 3'd0, 16'h0020, 1'b1);
    r.jloc = 16'h0010; r.jvalid = 1'b1;
    exp_q.push_back(r);
    issue(16'hBBF0, 16'h0020);
    exp_q.push_back(mk(4'd0, 3'd2, 3'd3, 3'd4, 6'd0, 9'd0, 3'd1, 16'h0022, 1'b1));
    issue({4'd0, 3'd2, 3'd3, 3'd4, 3'd1}, 16'h0022);

    // Opcode 14: consumed, illegal pulse, no valid beat.
    r = '0; r.illegal = 1'b1;
    exp_q.push_back(r);
    issue({4'd14, 12'h123}, 16'h0030);
    step();
    check("illegal_pulse_cleared", 128'(illegal), 128'(0));

    // SM with empty mask: consumed silently, stage stays ready.
    issue({4'd7, 3'd1, 1'b0, 8'h00}, 16'h0040);
    #1;
    check("sm_empty_in_ready", 128'(in_ready), 128'(1));
    check("sm_empty_valid", 128'(valid_out), 128'(0));
    step();

    // LM r2, mask 1001_0010 -> rc 1/4/7, offsets 0/1/2, in_ready low 3 cycles.
    exp_q.push_back(mku(4'd6, 3'd2, 3'd0, 3'd1, 16'h0050, 16'd0, 1'b0));
    exp_q.push_back(mku(4'd6, 3'd2, 3'd0, 3'd4, 16'h0050, 16'd1, 1'b0));
    exp_q.push_back(mku(4'd6, 3'd2, 3'd0, 3'd7, 16'h0050, 16'd2, 1'b1));
    issue({4'd6, 3'd2, 1'b0, 8'h92}, 16'h0050);
    zeros = 0;
    for (int k = 0; k < 6; k++) begin
      #1; if (!in_ready) zeros++;
      step();
    end
    check("lm_in_ready_low_cycles", 128'(zeros), 128'(3));

    // SM r3, mask 0x31 with a 4-cycle RR stall on the first micro-op.
    exp_q.push_back(mku(4'd7, 3'd3, 3'd0, 3'd0, 16'h0060, 16'd0, 1'b0));
    exp_q.push_back(mku(4'd7, 3'd3, 3'd4, 3'd0, 16'h0060, 16'd1, 1'b0));
    exp_q.push_back(mku(4'd7, 3'd3, 3'd5, 3'd0, 16'h0060, 16'd2, 1'b1));
    issue({4'd7, 3'd3, 1'b0, 8'h31}, 16'h0060);
    wait_valid();
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    repeat (6) step();

    // LM r4, mask 0x0E: flush while the 2nd micro-op is held; an instruction
    // presented in the flush cycle must be dropped.
    exp_q.push_back(mku(4'd6, 3'd4, 3'd0, 3'd1, 16'h0070, 16'd0, 1'b0));
    issue({4'd6, 3'd4, 1'b0, 8'h0E}, 16'h0070);
    wait_valid();
    step();
    flush = 1'b1; out_ready = 1'b0;
    instr = 16'h0298; PC_in = 16'h0072; valid_f = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1; valid_f = 1'b0;
    #1;
    check("flush_valid_out", 128'(valid_out), 128'(0));
    check("flush_uop", 128'(uop), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    step();
    exp_q.push_back(mk(4'd0, 3'd5, 3'd6, 3'd7, 6'd0, 9'd0, 3'd1, 16'h0080, 1'b1));
    issue({4'd0, 3'd5, 3'd6, 3'd7, 3'd1}, 16'h0080);
    repeat (8) step();
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
